// File: rtl/puf_soc_pkg.sv
// puf_soc_pkg: shared FSM state encoding for the PUF sequencer, assembler and debug decoders
package puf_soc_pkg;
  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR   = 3'd1;
  localparam logic [ST_W-1:0] ST_SETTLE  = 3'd2;
  localparam logic [ST_W-1:0] ST_COUNT   = 3'd3;
  localparam logic [ST_W-1:0] ST_CAPTURE = 3'd4;
  localparam logic [ST_W-1:0] ST_NEXT    = 3'd5;
  localparam logic [ST_W-1:0] ST_DONE    = 3'd6;
  localparam logic [ST_W-1:0] ST_ILLEGAL = 3'd7;
  typedef enum logic [ST_W-1:0] {
    IDLE    = ST_IDLE,
    CLEAR   = ST_CLEAR,
    SETTLE  = ST_SETTLE,
    COUNT   = ST_COUNT,
    CAPTURE = ST_CAPTURE,
    NEXT    = ST_NEXT,
    DONE    = ST_DONE,
    ILLEGAL = ST_ILLEGAL
  } state_t;
endpackage

// File: rtl/puf_meas_sequencer_if.sv
// puf_meas_sequencer_if: control inputs and datapath/status outputs of the measurement sequencer
interface puf_meas_sequencer_if
  import puf_soc_pkg::*;
#(
  parameter int MUX_LENGTH   = 16,
  parameter int WIN_BIT_SIZE = 16
);
  logic                          i_start;
  logic                          i_cont;
  logic                          i_abort;
  logic [WIN_BIT_SIZE-1:0]       i_win_len;
  logic                          i_full_0;
  logic                          i_full_1;
  logic [$clog2(MUX_LENGTH)-1:0] o_sel_mux_0;
  logic [$clog2(MUX_LENGTH)-1:0] o_sel_mux_1;
  logic [MUX_LENGTH-1:0]         o_ro_bnk_en;
  logic                          o_cnt_clr;
  logic                          o_cnt_en;
  logic                          o_assmblr_en;
  logic [ST_W-1:0]               o_fsm_state;
  logic                          o_busy;
  logic                          o_done;
  logic                          o_sat;
  modport master (
    output i_start, i_cont, i_abort, i_win_len, i_full_0, i_full_1,
    input  o_sel_mux_0, o_sel_mux_1, o_ro_bnk_en, o_cnt_clr, o_cnt_en,
           o_assmblr_en, o_fsm_state, o_busy, o_done, o_sat
  );
  modport slave (
    input  i_start, i_cont, i_abort, i_win_len, i_full_0, i_full_1,
    output o_sel_mux_0, o_sel_mux_1, o_ro_bnk_en, o_cnt_clr, o_cnt_en,
           o_assmblr_en, o_fsm_state, o_busy, o_done, o_sat
  );
endinterface

// File: rtl/puf_win_timer.sv
// puf_win_timer: loadable down-counter; tc marks the last cycle of the loaded duration
module puf_win_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  // load sets the duration in cycles; counting stops at zero so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= load ? load_val : (cnt != '0) ? cnt - W'(1) : cnt;
  end
  assign tc = cnt == W'(1);
endmodule

// File: rtl/puf_meas_sequencer.sv
// puf_meas_sequencer: sweeps all RO pairs through clear/settle/count/capture
module puf_meas_sequencer
  import puf_soc_pkg::*;
#(
  parameter int MUX_LENGTH   = 16,
  parameter int WIN_BIT_SIZE = 16,
  parameter int SETTLE_CYC   = 4
) (
  input logic                 clk,
  input logic                 rst,
  puf_meas_sequencer_if.slave bus
);
  localparam int SW = $clog2(MUX_LENGTH);
  localparam int P  = MUX_LENGTH / 2;
  state_t                  state, state_nxt;
  logic [SW-1:0]           k;
  logic                    sat, tc, load, full, last, k_clr, k_inc;
  logic [WIN_BIT_SIZE-1:0] load_val, win_eff;
  assign full     = bus.i_full_0 | bus.i_full_1;
  assign last     = k == SW'(P - 1);
  assign win_eff  = (bus.i_win_len == '0) ? WIN_BIT_SIZE'(1) : bus.i_win_len;
  assign load     = (state == CLEAR) | ((state == SETTLE) & tc);
  assign load_val = (state == CLEAR) ? WIN_BIT_SIZE'(SETTLE_CYC) : win_eff;
  assign k_clr    = (state_nxt == CLEAR) & ((state == IDLE) | (state == DONE));
  assign k_inc    = (state == NEXT) & (state_nxt == CLEAR);
  puf_win_timer #(.W(WIN_BIT_SIZE)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );
  // next-state selection; abort overrides every non-idle transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.i_start ? CLEAR : IDLE;
      CLEAR:   state_nxt = SETTLE;
      SETTLE:  state_nxt = tc ? COUNT : SETTLE;
      COUNT:   state_nxt = (tc | full) ? CAPTURE : COUNT;
      CAPTURE: state_nxt = last ? DONE : NEXT;
      NEXT:    state_nxt = CLEAR;
      DONE:    state_nxt = bus.i_cont ? CLEAR : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.i_abort && state != IDLE) state_nxt = IDLE;
  end
  // state, pair index and sticky saturation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_clr ? '0 : k_inc ? k + SW'(1) : k;
      sat   <= k_clr ? 1'b0 : ((state == COUNT) & full) ? 1'b1 : sat;
    end
  end
  assign bus.o_sel_mux_0  = (state == IDLE) ? '0 : SW'({k, 1'b0});
  assign bus.o_sel_mux_1  = (state == IDLE) ? '0 : SW'({k, 1'b1});
  assign bus.o_ro_bnk_en  = ((state == SETTLE) | (state == COUNT)) ? MUX_LENGTH'(3) << {k, 1'b0} : '0;
  assign bus.o_cnt_clr    = state == CLEAR;
  assign bus.o_cnt_en     = state == COUNT;
  assign bus.o_assmblr_en = state == CAPTURE;
  assign bus.o_fsm_state  = state;
  assign bus.o_busy       = state != IDLE;
  assign bus.o_done       = state == DONE;
  assign bus.o_sat        = sat;
endmodule

// File: tb/tb_puf_meas_sequencer.sv
// tb_puf_meas_sequencer: directed checks of sweep timing, early capture, abort, continuous mode and reset
module tb_puf_meas_sequencer;
  import puf_soc_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cap_n, last_cap, en_run, done_cyc, prev_clr, cnt_c, aborted, dn, d1, after_done;
  always #5 clk = ~clk;
  puf_meas_sequencer_if #(.MUX_LENGTH(16), .WIN_BIT_SIZE(16)) bus ();
  puf_meas_sequencer #(.MUX_LENGTH(16), .WIN_BIT_SIZE(16), .SETTLE_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    bus.i_start = 1'b1;
    tick;
    bus.i_start = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_cont = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_win_len = 16'd10;
    bus.i_full_0 = 1'b0;
    bus.i_full_1 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("rst_state", 32'(bus.o_fsm_state), 32'(ST_IDLE));
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_sel", 32'({bus.o_sel_mux_0, bus.o_sel_mux_1}), 0);
    chk("rst_ro", 32'(bus.o_ro_bnk_en), 0);
    chk("rst_ctl", 32'({bus.o_cnt_clr, bus.o_cnt_en, bus.o_assmblr_en, bus.o_done, bus.o_sat}), 0);
    // full sweep, W=10: capture every 17 cycles, DONE is the 136th cycle from CLEAR
    pulse_start;
    chk("t1_clear", 32'(bus.o_fsm_state), 32'(ST_CLEAR));
    chk("t1_clr0", 32'(bus.o_cnt_clr), 1);
    cap_n = 0; last_cap = 0; en_run = 0; done_cyc = -1; prev_clr = 1;
    for (int c = 1; c < 200 && done_cyc < 0; c++) begin
      tick;
      if (prev_clr != 0) chk("t1_clr_then_settle", 32'(bus.o_fsm_state), 32'(ST_SETTLE));
      prev_clr = int'(bus.o_cnt_clr);
      if (bus.o_cnt_en) en_run++;
      if (bus.o_fsm_state == ST_SETTLE || bus.o_fsm_state == ST_COUNT)
        chk("t1_ro", 32'(bus.o_ro_bnk_en), 32'h3 << (2 * cap_n));
      if (bus.o_assmblr_en) begin
        chk("t1_sel0", 32'(bus.o_sel_mux_0), 2 * cap_n);
        chk("t1_sel1", 32'(bus.o_sel_mux_1), 2 * cap_n + 1);
        chk("t1_win", en_run, 10);
        chk("t1_en_off", 32'(bus.o_cnt_en), 0);
        if (cap_n > 0) chk("t1_gap", c - last_cap, 17);
        last_cap = c; cap_n++; en_run = 0;
      end
      if (bus.o_done) done_cyc = c;
    end
    chk("t1_caps", cap_n, 8);
    chk("t1_done_cyc", done_cyc, 135);
    tick;
    chk("t1_idle", 32'(bus.o_fsm_state), 32'(ST_IDLE));
    chk("t1_busy", 32'(bus.o_busy), 0);
    chk("t1_sat", 32'(bus.o_sat), 0);
    // full_1 on the 3rd COUNT cycle of pair 2 cuts that window to 3 cycles
    pulse_start;
    cap_n = 0; cnt_c = 0; en_run = 0; done_cyc = -1;
    for (int c = 1; c < 200 && done_cyc < 0; c++) begin
      tick;
      if (bus.i_full_1) begin
        bus.i_full_1 = 1'b0;
        chk("t2_early_cap", 32'(bus.o_fsm_state), 32'(ST_CAPTURE));
        chk("t2_sat_set", 32'(bus.o_sat), 1);
      end
      if (bus.o_cnt_en) en_run++;
      if (cap_n == 2 && bus.o_fsm_state == ST_COUNT) begin
        cnt_c++;
        if (cnt_c == 3) bus.i_full_1 = 1'b1;
      end
      if (bus.o_assmblr_en) begin
        if (cap_n == 2) chk("t2_short_win", en_run, 3);
        cap_n++; en_run = 0;
      end
      if (bus.o_done) begin
        done_cyc = c;
        chk("t2_done_sat", 32'(bus.o_sat), 1);
      end
    end
    chk("t2_caps", cap_n, 8);
    chk("t2_done_cyc", done_cyc, 128);
    tick;
    chk("t2_idle", 32'(bus.o_fsm_state), 32'(ST_IDLE));
    chk("t2_sat_sticky", 32'(bus.o_sat), 1);
    // abort during COUNT of pair 5
    pulse_start;
    chk("t3_sat_clr", 32'(bus.o_sat), 0);
    cap_n = 0; aborted = 0;
    for (int c = 1; c < 200 && aborted == 0; c++) begin
      tick;
      if (bus.o_assmblr_en) cap_n++;
      if (cap_n == 5 && bus.o_fsm_state == ST_COUNT) begin
        bus.i_abort = 1'b1;
        aborted = 1;
      end
    end
    chk("t3_reached", aborted, 1);
    tick;
    bus.i_abort = 1'b0;
    chk("t3_idle", 32'(bus.o_fsm_state), 32'(ST_IDLE));
    chk("t3_outs", {bus.o_sel_mux_0, bus.o_sel_mux_1, bus.o_ro_bnk_en}, 0);
    chk("t3_ctl", 32'({bus.o_cnt_clr, bus.o_cnt_en, bus.o_assmblr_en, bus.o_done, bus.o_busy}), 0);
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (bus.o_done || bus.o_assmblr_en) dn++;
    end
    chk("t3_no_done", dn, 0);
    pulse_start;
    chk("t3_restart", 32'(bus.o_fsm_state), 32'(ST_CLEAR));
    tick;
    chk("t3_settle", 32'(bus.o_fsm_state), 32'(ST_SETTLE));
    chk("t3_ro0", 32'(bus.o_ro_bnk_en), 32'h0003);
    chk("t3_sel", 32'({bus.o_sel_mux_0, bus.o_sel_mux_1}), 32'h01);
    bus.i_abort = 1'b1;
    tick;
    bus.i_abort = 1'b0;
    chk("t3_abort2", 32'(bus.o_fsm_state), 32'(ST_IDLE));
    // continuous mode with a zero window: 8-cycle pairs, 64-cycle sweeps
    bus.i_win_len = 16'd0;
    bus.i_cont = 1'b1;
    pulse_start;
    dn = 0; d1 = -1; en_run = 0; after_done = 0;
    for (int c = 1; c < 400 && dn < 3; c++) begin
      tick;
      if (after_done != 0) begin
        chk("t4_restart", 32'(bus.o_fsm_state), 32'(ST_CLEAR));
        chk("t4_k0", 32'({bus.o_sel_mux_0, bus.o_sel_mux_1}), 32'h01);
        after_done = 0;
        if (dn == 2) bus.i_cont = 1'b0;
      end
      if (bus.o_cnt_en) en_run++;
      if (bus.o_assmblr_en) begin
        chk("t4_win1", en_run, 1);
        en_run = 0;
      end
      if (bus.o_done) begin
        dn++;
        if (dn == 1) d1 = c;
        if (dn == 2) chk("t4_period", c - d1, 64);
        after_done = 1;
      end
    end
    chk("t4_dones", dn, 3);
    chk("t4_first_done", d1, 63);
    tick;
    chk("t4_idle", 32'(bus.o_fsm_state), 32'(ST_IDLE));
    chk("t4_busy", 32'(bus.o_busy), 0);
    // asynchronous reset mid-SETTLE, then recovery from the illegal code
    bus.i_win_len = 16'd10;
    pulse_start;
    tick;
    chk("t5_settle", 32'(bus.o_fsm_state), 32'(ST_SETTLE));
    chk("t5_ro", 32'(bus.o_ro_bnk_en), 32'h0003);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_state", 32'(bus.o_fsm_state), 32'(ST_IDLE));
    chk("t5_async_ro", 32'(bus.o_ro_bnk_en), 0);
    chk("t5_async_ctl", 32'({bus.o_busy, bus.o_cnt_clr, bus.o_cnt_en, bus.o_sel_mux_0, bus.o_sel_mux_1}), 0);
    tick;
    rst = 1'b0;
    tick;
    force dut.state = ILLEGAL;
    #1;
    chk("t5_forced", 32'(bus.o_fsm_state), 32'(ST_ILLEGAL));
    release dut.state;
    tick;
    chk("t5_illegal_recover", 32'(bus.o_fsm_state), 32'(ST_IDLE));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
